// File: rtl/blob_stream_feeder_pkg.sv
// Shared constants and types for the blob labeler and its pixel feeder.
// Frame geometry here must match the labeler build.
package blob_pkg;

  localparam int IMG_ROW = 480;
  localparam int IMG_COL = 640;
  localparam int TOTAL   = IMG_ROW * IMG_COL;
  localparam int PIX_W   = 12;

  typedef logic [PIX_W-1:0] pix_t;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_STREAM      = 2'd1,
    ST_PAD         = 2'd2,
    ST_WAIT_RESULT = 2'd3
  } feed_state_t;

endpackage

// File: rtl/blob_stream_feeder_rgb2bin.sv
// Two-stage RGB -> gray -> 1-bit threshold pipeline.
// Threshold and invert travel with the pixel so a frame's first pixel uses its own settings.
module rgb2bin
  import blob_pkg::*;
#(
  parameter int PIX_W = blob_pkg::PIX_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [PIX_W-1:0] i_red,
  input  logic [PIX_W-1:0] i_green,
  input  logic [PIX_W-1:0] i_blue,
  input  logic [PIX_W-1:0] i_thr,
  input  logic             i_invert,
  output logic             o_valid,
  output logic             o_bit,
  output logic             o_busy
);

  logic [PIX_W+1:0] w_sum;
  logic [PIX_W-1:0] w_gray;

  logic             r_s1_valid;
  logic [PIX_W-1:0] r_s1_gray;
  logic [PIX_W-1:0] r_s1_thr;
  logic             r_s1_invert;
  logic             r_s2_valid;
  logic             r_s2_bit;

  // R + 2G + B cannot overflow PIX_W+2 bits; dividing by 4 brings it back to PIX_W.
  assign w_sum  = {2'b00, i_red} + {1'b0, i_green, 1'b0} + {2'b00, i_blue};
  assign w_gray = PIX_W'(w_sum >> 2);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_gray   <= '0;
      r_s1_thr    <= '0;
      r_s1_invert <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s2_bit    <= 1'b0;
    end else begin
      r_s1_valid  <= i_valid;
      r_s1_gray   <= w_gray;
      r_s1_thr    <= i_thr;
      r_s1_invert <= i_invert;
      r_s2_valid  <= r_s1_valid;
      if (r_s1_valid)
        r_s2_bit <= r_s1_invert ? (r_s1_gray < r_s1_thr) : (r_s1_gray >= r_s1_thr);
      else
        r_s2_bit <= 1'b0;
    end
  end

  assign o_valid = r_s2_valid;
  assign o_bit   = r_s2_bit;
  assign o_busy  = r_s1_valid | r_s2_valid;

endmodule

// File: rtl/blob_stream_feeder.sv
// Feeds exactly IMG_ROW*IMG_COL binarized pixels per frame to the blob labeler
// and captures the labeler's count (or a timeout) afterwards.
module blob_stream_feeder
  import blob_pkg::*;
#(
  parameter int IMG_ROW        = blob_pkg::IMG_ROW,
  parameter int IMG_COL        = blob_pkg::IMG_COL,
  parameter int PIX_W          = blob_pkg::PIX_W,
  parameter int RESULT_TIMEOUT = 1000000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_pix_valid,
  input  logic             i_sof,
  input  logic [PIX_W-1:0] i_red,
  input  logic [PIX_W-1:0] i_green,
  input  logic [PIX_W-1:0] i_blue,
  input  logic [PIX_W-1:0] i_threshold,
  input  logic             i_invert,
  output logic             o_valid,
  output logic             o_seq,
  input  logic             i_blob_valid,
  input  logic [7:0]       i_blob_count,
  output logic [7:0]       o_count,
  output logic             o_count_valid,
  output logic             o_timeout,
  output logic             o_busy
);

  localparam int FRAME_TOTAL = IMG_ROW * IMG_COL;
  localparam int CNT_W       = $clog2(FRAME_TOTAL + 1);
  localparam int TO_W        = $clog2(RESULT_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_TOTAL - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(RESULT_TIMEOUT - 1);

  feed_state_t      r_state;
  feed_state_t      w_next_state;
  logic [CNT_W-1:0] r_in_cnt;
  logic [CNT_W-1:0] r_out_cnt;
  logic [TO_W-1:0]  r_to_cnt;
  logic [PIX_W-1:0] r_thr;
  logic             r_invert;
  logic             r_pad_valid;
  logic             r_count_valid;
  logic             r_timeout;
  logic [7:0]       r_count;

  logic             w_sof_start;
  logic             w_accept;
  logic             w_pad_emit;
  logic [PIX_W-1:0] w_thr;
  logic             w_invert;
  logic             w_pipe_valid;
  logic             w_pipe_bit;
  logic             w_pipe_busy;

  assign w_sof_start = (r_state == ST_IDLE) && i_pix_valid && i_sof;
  assign w_accept    = w_sof_start || ((r_state == ST_STREAM) && i_pix_valid && !i_sof);
  // Padding waits for the pipeline to drain so pad bits never collide with pixel bits.
  assign w_pad_emit  = (r_state == ST_PAD) && !w_pipe_busy;
  assign w_thr       = w_sof_start ? i_threshold : r_thr;
  assign w_invert    = w_sof_start ? i_invert : r_invert;

  rgb2bin #(
    .PIX_W (PIX_W)
  ) u_rgb2bin (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (w_accept),
    .i_red    (i_red),
    .i_green  (i_green),
    .i_blue   (i_blue),
    .i_thr    (w_thr),
    .i_invert (w_invert),
    .o_valid  (w_pipe_valid),
    .o_bit    (w_pipe_bit),
    .o_busy   (w_pipe_busy)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_sof_start)
          w_next_state = (FRAME_TOTAL == 1) ? ST_WAIT_RESULT : ST_STREAM;
      end
      ST_STREAM: begin
        if (i_pix_valid) begin
          if (i_sof)
            w_next_state = ST_PAD;
          else if (r_in_cnt == LAST_IDX)
            w_next_state = ST_WAIT_RESULT;
        end
      end
      ST_PAD: begin
        if (w_pad_emit && (r_in_cnt == LAST_IDX))
          w_next_state = ST_WAIT_RESULT;
      end
      ST_WAIT_RESULT: begin
        if (i_blob_valid || (r_to_cnt == TO_LAST))
          w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // r_in_cnt counts bits issued this frame: accepted pixels, then pad bits.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_in_cnt      <= '0;
      r_out_cnt     <= '0;
      r_to_cnt      <= '0;
      r_thr         <= '0;
      r_invert      <= 1'b0;
      r_pad_valid   <= 1'b0;
      r_count_valid <= 1'b0;
      r_timeout     <= 1'b0;
      r_count       <= '0;
    end else begin
      r_state       <= w_next_state;
      r_pad_valid   <= w_pad_emit;
      r_count_valid <= 1'b0;

      if (w_sof_start) begin
        r_thr     <= i_threshold;
        r_invert  <= i_invert;
        r_in_cnt  <= CNT_W'(1);
        r_timeout <= 1'b0;
      end else if (((r_state == ST_STREAM) && w_accept) || w_pad_emit) begin
        r_in_cnt <= r_in_cnt + 1'b1;
      end

      if (o_valid)
        r_out_cnt <= (r_out_cnt == LAST_IDX) ? '0 : r_out_cnt + 1'b1;

      if (r_state == ST_WAIT_RESULT) begin
        r_to_cnt <= r_to_cnt + 1'b1;
        if (i_blob_valid) begin
          r_count       <= i_blob_count;
          r_count_valid <= 1'b1;
        end else if (r_to_cnt == TO_LAST) begin
          r_timeout <= 1'b1;
        end
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  assign o_valid       = w_pipe_valid | r_pad_valid;
  assign o_seq         = w_pipe_bit;
  assign o_count       = r_count;
  assign o_count_valid = r_count_valid;
  assign o_timeout     = r_timeout;
  assign o_busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_blob_stream_feeder.sv
// Directed bench for blob_stream_feeder on a 4x8 frame with a 50-cycle result timeout.
module tb_blob_stream_feeder;

  localparam int TOT = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pv, sof, inv, blob_v;
  logic [11:0] r, g, b, thr;
  logic [7:0]  blob_cnt;
  logic        o_valid, o_seq, o_count_valid, o_timeout, o_busy;
  logic [7:0]  o_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic exp_q[$];
  int   exp_cyc[$];
  logic obs_q[$];
  int   obs_cyc[$];

  blob_stream_feeder #(
    .IMG_ROW(4), .IMG_COL(8), .PIX_W(12), .RESULT_TIMEOUT(50)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_valid(pv), .i_sof(sof),
    .i_red(r), .i_green(g), .i_blue(b), .i_threshold(thr), .i_invert(inv),
    .o_valid(o_valid), .o_seq(o_seq),
    .i_blob_valid(blob_v), .i_blob_count(blob_cnt),
    .o_count(o_count), .o_count_valid(o_count_valid),
    .o_timeout(o_timeout), .o_busy(o_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_valid) begin
      obs_q.push_back(o_seq);
      obs_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    pv = 1'b0; sof = 1'b0; r = '0; g = '0; b = '0;
  endtask

  task automatic gap(input int n);
    idle_in();
    repeat (n) tick();
  endtask

  task automatic drive_pix(input logic s, input logic [11:0] v);
    pv = 1'b1; sof = s; r = v; g = v; b = v;
    tick();
    idle_in();
  endtask

  task automatic send_result(input logic [7:0] c);
    blob_v = 1'b1; blob_cnt = c;
    tick();
    blob_v = 1'b0; blob_cnt = '0;
  endtask

  task automatic clear_scb();
    exp_q.delete(); exp_cyc.delete(); obs_q.delete(); obs_cyc.delete();
  endtask

  task automatic compare_stream(input string name);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL %s_count: got %0d want %0d", name, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= obs_q.size()) begin
        bad++; $display("FAIL %s_bit%0d: missing, want %0b", name, i, exp_q[i]);
      end else if (obs_q[i] !== exp_q[i] || (exp_cyc[i] >= 0 && obs_cyc[i] != exp_cyc[i])) begin
        bad++; $display("FAIL %s_bit%0d: got %0b@%0d want %0b@%0d", name, i,
                        obs_q[i], obs_cyc[i], exp_q[i], exp_cyc[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle_in(); thr = '0; inv = 1'b0; blob_v = 1'b0; blob_cnt = '0;
    repeat (3) tick();
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    total++; if (o_seq !== 1'b0) begin bad++; $display("FAIL reset_seq: got %b want 0", o_seq); end
    total++; if (o_count_valid !== 1'b0) begin bad++; $display("FAIL reset_cv: got %b want 0", o_count_valid); end
    total++; if (o_timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b want 0", o_timeout); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    total++; if (o_count !== 8'h00) begin bad++; $display("FAIL reset_count: got %h want 00", o_count); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_frame();
    int c0;
    clear_scb();
    thr = 12'h800; inv = 1'b0;
    repeat (3) drive_pix(1'b0, 12'hFFF);
    gap(3);
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL idle_nosof_out: got %0d want 0", obs_q.size()); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL idle_nosof_busy: got %b want 0", o_busy); end
    c0 = cyc;
    for (int i = 0; i < TOT; i++) begin
      exp_q.push_back((i % 2) == 0);
      exp_cyc.push_back(c0 + i + 2);
      drive_pix(i == 0, (i % 2 == 0) ? 12'hFFF : 12'h000);
    end
    gap(4);
    compare_stream("full");
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL full_wait_busy: got %b want 1", o_busy); end
  endtask

  task automatic test_result_capture();
    blob_v = 1'b1; blob_cnt = 8'h2A;
    tick();
    blob_v = 1'b0; blob_cnt = '0;
    total++; if (o_count_valid !== 1'b1) begin bad++; $display("FAIL cap_pulse: got %b want 1", o_count_valid); end
    total++; if (o_count !== 8'h2A) begin bad++; $display("FAIL cap_count: got %h want 2a", o_count); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL cap_idle: got %b want 0", o_busy); end
    tick();
    total++; if (o_count_valid !== 1'b0) begin bad++; $display("FAIL cap_pulse_width: got %b want 0", o_count_valid); end
    send_result(8'h55);
    total++; if (o_count_valid !== 1'b0) begin bad++; $display("FAIL idle_result_pulse: got %b want 0", o_count_valid); end
    total++; if (o_count !== 8'h2A) begin bad++; $display("FAIL idle_result_count: got %h want 2a", o_count); end
  endtask

  task automatic test_invert_gaps();
    clear_scb();
    thr = 12'h800; inv = 1'b1;
    for (int i = 0; i < TOT; i++) begin
      if (i % 3 == 1) gap(1);
      if (i % 5 == 2) gap(2);
      exp_q.push_back(1'b1);
      exp_cyc.push_back(cyc + 2);
      drive_pix(i == 0, 12'h7FF);
    end
    gap(4);
    compare_stream("inv");
    inv = 1'b0;
    send_result(8'h07);
    total++; if (o_count !== 8'h07) begin bad++; $display("FAIL inv_result: got %h want 07", o_count); end
  endtask

  task automatic test_early_sof();
    clear_scb();
    thr = 12'h800; inv = 1'b0;
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(1'b1);
      exp_cyc.push_back(cyc + 2);
      drive_pix(i == 0, 12'hFFF);
    end
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back(1'b0);
      exp_cyc.push_back(-1);
    end
    for (int j = 0; j < 16; j++) drive_pix(j == 0, 12'hFFF);
    gap(8);
    compare_stream("early");
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL early_busy: got %b want 1", o_busy); end
    total++; if (o_timeout !== 1'b0) begin bad++; $display("FAIL early_timeout: got %b want 0", o_timeout); end
    drive_pix(1'b1, 12'hFFF);
    gap(3);
    total++; if (obs_q.size() != TOT) begin bad++; $display("FAIL early_wait_sof: got %0d want %0d", obs_q.size(), TOT); end
    send_result(8'h33);
    total++; if (o_count !== 8'h33) begin bad++; $display("FAIL early_result: got %h want 33", o_count); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL early_idle: got %b want 0", o_busy); end
  endtask

  task automatic test_timeout();
    clear_scb();
    for (int i = 0; i < TOT; i++) drive_pix(i == 0, 12'h123);
    repeat (49) tick();
    total++; if (o_timeout !== 1'b0) begin bad++; $display("FAIL to_early: got %b want 0", o_timeout); end
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL to_busy: got %b want 1", o_busy); end
    tick();
    total++; if (o_timeout !== 1'b1) begin bad++; $display("FAIL to_set: got %b want 1", o_timeout); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL to_idle: got %b want 0", o_busy); end
    total++; if (o_count !== 8'h33) begin bad++; $display("FAIL to_count_kept: got %h want 33", o_count); end
    total++; if (obs_q.size() != TOT) begin bad++; $display("FAIL to_stream: got %0d want %0d", obs_q.size(), TOT); end
    repeat (3) tick();
    total++; if (o_timeout !== 1'b1) begin bad++; $display("FAIL to_sticky: got %b want 1", o_timeout); end
    drive_pix(1'b1, 12'h000);
    total++; if (o_timeout !== 1'b0) begin bad++; $display("FAIL to_clear: got %b want 0", o_timeout); end
    for (int i = 1; i < TOT; i++) drive_pix(1'b0, 12'h000);
    gap(4);
    send_result(8'h44);
    total++; if (o_count !== 8'h44) begin bad++; $display("FAIL to_next_result: got %h want 44", o_count); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 10; i++) drive_pix(i == 0, 12'hFFF);
    pv = 1'b1; r = 12'hFFF; g = 12'hFFF; b = 12'hFFF;
    #3;
    rst_n = 1'b0;
    #1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid: got %b want 0", o_valid); end
    total++; if (o_seq !== 1'b0) begin bad++; $display("FAIL rst_mid_seq: got %b want 0", o_seq); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b want 0", o_busy); end
    total++; if (o_count !== 8'h00) begin bad++; $display("FAIL rst_mid_count: got %h want 00", o_count); end
    idle_in();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    clear_scb();
    for (int i = 0; i < TOT; i++) begin
      exp_q.push_back((i % 2) == 0);
      exp_cyc.push_back(cyc + 2);
      drive_pix(i == 0, (i % 2 == 0) ? 12'hFFF : 12'h000);
    end
    gap(5);
    compare_stream("post_rst");
    send_result(8'h09);
    total++; if (o_count !== 8'h09) begin bad++; $display("FAIL post_rst_result: got %h want 09", o_count); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_result_capture();
    test_invert_gaps();
    test_early_sof();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
